// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing blocks:
//   - vga_mode_t   : one complete set of horizontal/vertical timing numbers
//                    together with the sync polarities of that mode
//   - MODE_640X480_60 / MODE_800X600_60 : standard timing sets
//   - width_for()  : number of bits needed to count 0..n-1, used to check
//                    that a counter width can hold the whole raster axis
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        bit          hsync_pol;
        bit          vsync_pol;
    } vga_mode_t;

    // 640x480@60, 25.175 MHz pixel clock, both syncs active-low.
    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        hsync_pol: 1'b0, vsync_pol: 1'b0
    };

    // 800x600@60, 40 MHz pixel clock, both syncs active-high.
    localparam vga_mode_t MODE_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        hsync_pol: 1'b1, vsync_pol: 1'b1
    };

    // Smallest w >= 1 with 2^w >= n.
    function automatic int unsigned width_for(input int unsigned n);
        int unsigned r;
        r = 31;
        for (int i = 31; i >= 1; i--) begin
            if ((64'd1 << i) >= 64'(n)) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Wrapping counter for one raster axis. Counts 0..TOTAL-1 on each step and
// resets to TOTAL-1 so that the first step lands on 0.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (count <= TOTAL-1)
//   step       in   advance by one position this clk
//   count      out  current (registered) position
//   count_next out  position the counter takes at the next edge (no reset)
//   wrap       out  step taken at TOTAL-1, i.e. count_next returns to 0
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    if (width_for(TOTAL) > W) begin : g_width_check
        $error("vga_axis_counter: W too small for TOTAL");
    end

    always_comb begin
        wrap       = step && (count == LAST);
        count_next = count;
        if (step) begin
            count_next = wrap ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= LAST;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Advances one pixel per clk where
// pix_en && enable, and registers sync/blank/active flags decoded from the
// post-step coordinates so every flag matches hcount/vcount on the same clk.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   pix_en       in   pixel-rate strobe
//   enable       in   run control; 0 freezes the raster and suppresses pulses
//   hsync        out  horizontal sync, asserted level = HSYNC_POL
//   vsync        out  vertical sync, asserted level = VSYNC_POL
//   active_video out  pixel is inside the visible area
//   hblank       out  hcount >= H_ACTIVE
//   vblank       out  vcount >= V_ACTIVE
//   hcount       out  current column
//   vcount       out  current line
//   line_start   out  one-clk pulse when hcount steps to 0
//   frame_start  out  one-clk pulse when the raster steps to (0,0)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned HW        = 10,
    parameter int unsigned VW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          active_video,
    output logic          hblank,
    output logic          vblank,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    if (width_for(H_TOTAL) > HW) begin : g_hw_check
        $error("vga_timing_gen: HW too small for H_TOTAL");
    end
    if (width_for(V_TOTAL) > VW) begin : g_vw_check
        $error("vga_timing_gen: VW too small for V_TOTAL");
    end

    function automatic logic in_range(input logic [31:0] x,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (x >= lo) && (x <= hi);
    endfunction

    logic          step;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          h_wrap;
    logic          v_wrap;
    logic [31:0]   h_ext;
    logic [31:0]   v_ext;

    assign step  = pix_en && enable;
    assign h_ext = 32'(h_next);
    assign v_ext = 32'(v_next);

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .W     (HW)
    ) u_h_counter (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .count      (hcount),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    // The vertical axis advances exactly on the horizontal wrap.
    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .W     (VW)
    ) u_v_counter (
        .clk        (clk),
        .rst        (rst),
        .step       (h_wrap),
        .count      (vcount),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // Flags are decoded from the next coordinates; on a held clk those equal
    // the current ones, so levels hold and the wrap-driven pulses drop to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync        <= !HSYNC_POL;
            vsync        <= !VSYNC_POL;
            hblank       <= 1'b1;
            vblank       <= 1'b1;
            active_video <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            hsync        <= in_range(h_ext, HS_FIRST, HS_LAST) ? HSYNC_POL : !HSYNC_POL;
            vsync        <= in_range(v_ext, VS_FIRST, VS_LAST) ? VSYNC_POL : !VSYNC_POL;
            hblank       <= (h_ext >= H_ACTIVE);
            vblank       <= (v_ext >= V_ACTIVE);
            active_video <= (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
            line_start   <= h_wrap;
            frame_start  <= h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Bench for vga_timing_gen in a small 16x8 raster (H 8/2/3/3, V 4/1/2/1).
// A second instance with HSYNC_POL=1 shares the stimulus. The reference model
// tracks the raster as a single linear pixel index 0..127 and derives every
// expected output from the timing rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HT = 16;
    localparam int VT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic       enable = 1'b0;

    logic       hsync, vsync, active_video, hblank, vblank, line_start, frame_start;
    logic [3:0] hcount;
    logic [2:0] vcount;

    logic       hsync_p, vsync_p, active_video_p, hblank_p, vblank_p, line_start_p, frame_start_p;
    logic [3:0] hcount_p;
    logic [2:0] vcount_p;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HW(4), .VW(3)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .enable(enable),
        .hsync(hsync), .vsync(vsync), .active_video(active_video),
        .hblank(hblank), .vblank(vblank), .hcount(hcount), .vcount(vcount),
        .line_start(line_start), .frame_start(frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .HW(4), .VW(3)
    ) dut_pos (
        .clk(clk), .rst(rst), .pix_en(pix_en), .enable(enable),
        .hsync(hsync_p), .vsync(vsync_p), .active_video(active_video_p),
        .hblank(hblank_p), .vblank(vblank_p), .hcount(hcount_p), .vcount(vcount_p),
        .line_start(line_start_p), .frame_start(frame_start_p)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: linear raster index, pulses of the last clk.
    int mp = HT * VT - 1;
    bit m_ls = 1'b0;
    bit m_fs = 1'b0;

    int cyc = 0;
    int last_fs = -1;
    int exp_space = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d", tag, obs, obs, exp);
        end
    endtask

    task automatic check_all();
        int h, v;
        h = mp % HT;
        v = mp / HT;
        chk("hcount",       32'(hcount), 32'(h));
        chk("vcount",       32'(vcount), 32'(v));
        chk("hsync",        32'(hsync), 32'(!(h >= 10 && h <= 12)));
        chk("vsync",        32'(vsync), 32'(!(v >= 5 && v <= 6)));
        chk("hblank",       32'(hblank), 32'(h >= 8));
        chk("vblank",       32'(vblank), 32'(v >= 4));
        chk("active_video", 32'(active_video), 32'(h < 8 && v < 4));
        chk("line_start",   32'(line_start), 32'(m_ls));
        chk("frame_start",  32'(frame_start), 32'(m_fs));
        chk("hsync_pos",    32'(hsync_p), 32'(h >= 10 && h <= 12));
        chk("hcount_pos",   32'(hcount_p), 32'(h));
    endtask

    // Apply one clk of stimulus, advance the model, then check all outputs.
    task automatic tick(input bit pe, input bit en, input bit r);
        pix_en = pe;
        enable = en;
        rst    = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            mp = HT * VT - 1;
            m_ls = 1'b0;
            m_fs = 1'b0;
        end else if (pe && en) begin
            mp = (mp + 1) % (HT * VT);
            m_ls = (mp % HT) == 0;
            m_fs = (mp == 0);
        end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
        end
        #1;
        check_all();
        if (frame_start === 1'b1) begin
            if (exp_space != 0 && last_fs >= 0) chk("fs_spacing", 32'(cyc - last_fs), 32'(exp_space));
            last_fs = cyc;
        end
    endtask

    initial begin
        int n;

        // Reset state.
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk("rst_hcount", 32'(hcount), 32'd15);
        chk("rst_vcount", 32'(vcount), 32'd7);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_active", 32'(active_video), 32'd0);

        // First step lands on (0,0) with both pulses.
        tick(1'b1, 1'b1, 1'b0);
        chk("first_h", 32'(hcount), 32'd0);
        chk("first_v", 32'(vcount), 32'd0);
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("first_ls", 32'(line_start), 32'd1);
        chk("first_active", 32'(active_video), 32'd1);

        // Continuous pixel rate: two full frames and some.
        last_fs = cyc;
        exp_space = 128;
        for (int i = 0; i < 300; i++) tick(1'b1, 1'b1, 1'b0);

        // Strobe every 4th clk.
        last_fs = -1;
        exp_space = 512;
        for (int i = 0; i < 1600; i++) tick((i % 4) == 3, 1'b1, 1'b0);
        exp_space = 0;

        // Run to hcount=5, then freeze for 10 clks.
        n = 0;
        while ((mp % HT) != 5 && n < 200) begin
            tick(1'b1, 1'b1, 1'b0);
            n++;
        end
        if (n >= 200) chk("timeout_h5", 32'd0, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick($urandom_range(0, 1) == 1, 1'b0, 1'b0);
            chk("hold_h", 32'(hcount), 32'd5);
            chk("hold_ls", 32'(line_start), 32'd0);
        end
        tick(1'b1, 1'b1, 1'b0);
        chk("resume_h", 32'(hcount), 32'd6);

        // Randomised strobe/enable with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom % 4) != 0, ($urandom % 8) != 0, ($urandom % 200) == 0);
        end

        // Reset mid-frame at (9,3).
        n = 0;
        while (mp != 3 * HT + 9 && n < 300) begin
            tick(1'b1, 1'b1, 1'b0);
            n++;
        end
        if (n >= 300) chk("timeout_93", 32'd0, 32'd1);
        chk("pre_rst_h", 32'(hcount), 32'd9);
        chk("pre_rst_v", 32'(vcount), 32'd3);
        tick(1'b1, 1'b1, 1'b1);
        chk("midrst_h", 32'(hcount), 32'd15);
        chk("midrst_v", 32'(vcount), 32'd7);
        chk("midrst_hblank", 32'(hblank), 32'd1);
        chk("midrst_vblank", 32'(vblank), 32'd1);
        chk("midrst_fs", 32'(frame_start), 32'd0);
        tick(1'b1, 1'b1, 1'b0);
        chk("post_rst_fs", 32'(frame_start), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, successor to the fixed 640x480 sync block. It produces registered hsync, vsync, active_video, blanking flags and pixel coordinates for any mode set by parameters, with programmable sync polarity. It advances on a pixel-rate strobe from the shared system clock and adds run/hold control plus frame and line start pulses. It feeds the pixel-fetch and colour output stages.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync
HW, 10, hcount width; elaboration error if 2^HW < H_TOTAL
VW, 10, vcount width; elaboration error if 2^VW < V_TOTAL

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
pix_en  input  1  pixel-rate strobe; one raster step per clk with pix_en=1
enable  input  1  run control; 0 freezes the raster
hsync  output  1  horizontal sync, level per HSYNC_POL
vsync  output  1  vertical sync, level per VSYNC_POL
active_video  output  1  current pixel is visible
hblank  output  1  hcount >= H_ACTIVE
vblank  output  1  vcount >= V_ACTIVE
hcount  output  HW  current pixel column
vcount  output  VW  current line
line_start  output  1  one-clk pulse when hcount steps to 0
frame_start  output  1  one-clk pulse when raster steps to (0,0)

Behaviour:
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Step = pix_en and enable, sampled at posedge clk. Per step: hcount = (hcount = H_TOTAL-1) ? 0 : hcount+1. On hcount wrap: vcount = (vcount = V_TOTAL-1) ? 0 : vcount+1. No other counter changes.
- All outputs are registered and decoded from the updated count values, so every flag is coherent with hcount/vcount on the same cycle. Latency: one clk from the sampled step.
- hsync asserted iff H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1. vsync asserted iff V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1. Both bounds inclusive, so the pulse is exactly H_SYNC pixels / V_SYNC lines wide.
- active_video = !hblank && !vblank.
- line_start = 1 for exactly the clk after a step that wrapped hcount; frame_start likewise when both wrapped. Pulses are 0 on every non-step cycle.
- Reset state: hcount = H_TOTAL-1, vcount = V_TOTAL-1, hsync = vsync = deasserted, active_video = 0, hblank = vblank = 1, line_start = frame_start = 0. The first step after reset lands on (0,0) with both start pulses set.
- enable = 0: counts and levels hold; pulses forced to 0. Resuming continues from the held position.
- rst has priority over step; rst mid-frame returns to the reset state on the next edge.
- Counts never take values >= H_TOTAL or >= V_TOTAL.

Decomposition:
- Package vga_pkg: timing constant sets for 640x480@60 and 800x600@60, and a clog2-style width helper used for HW/VW checks.
- One sub-module, vga_axis_counter: generic wrapping counter (parameter TOTAL, inputs step and rst, outputs count and wrap). Instantiated for the h axis; the v instance steps on the h wrap.

Test Plan:
(Use small mode H=8/2/3/3 (H_TOTAL=16), V=4/1/2/1 (V_TOTAL=8), pix_en=1 unless stated.)
- Reset then enable=1 -> during reset hcount=15, vcount=7, hsync=vsync=1, active_video=0. First step gives (0,0), frame_start=1, line_start=1, active_video=1.
- Line sweep -> hsync=0 exactly for hcount 10..12. active_video=1 for hcount 0..7 on vcount 0..3. line_start pulses every 16 clks.
- Full frame -> vsync=0 exactly for vcount 5..6, vblank=1 for vcount 4..7, frame_start spacing 128 clks, no count reaches 16/8.
- pix_en high every 4th clk -> counts change only on strobe clks, start pulses exactly 1 clk wide, frame_start spacing 512 clks.
- enable dropped at hcount=5 for 10 clks -> hcount holds at 5, no pulses, next step gives 6.
- rst asserted at (9,3) -> next clk shows the reset state. Separate build with HSYNC_POL=1 -> hsync=1 only for hcount 10..12.
